// File: rtl/tone_sequencer.sv
// Song player: walks an external synchronous-read song memory and turns each {half_period, dur} entry into a square wave on speaker.
// Optional macro TONE_SEQ_ARTIC_GAP_EN silences the final tick of every note with dur >= 2.
module tone_sequencer #(
   parameter int CLK_HZ   = 100000000,
   parameter int TICK_HZ  = 16,
   parameter int SONG_LEN = 64,
   parameter int DIV_W    = 20,
   parameter int DUR_W    = 4,
   localparam int AW      = $clog2(SONG_LEN)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   loop,
   output logic [AW-1:0]          song_addr,
   input  logic [DIV_W+DUR_W-1:0] song_data,
   output logic                   speaker,
   output logic                   busy,
   output logic                   done
);

   localparam int TICKS = CLK_HZ / TICK_HZ;
   localparam int TW    = $clog2(TICKS);

   localparam logic [TW-1:0]    TICK_ZERO = TW'(0);
   localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
   localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS - 1);
   localparam logic [DUR_W-1:0] DUR_ZERO  = DUR_W'(0);
   localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
   localparam logic [DIV_W-1:0] HP_ZERO   = DIV_W'(0);
   localparam logic [DIV_W-1:0] HP_ONE    = DIV_W'(1);
   localparam logic [AW-1:0]    ADDR_ZERO = AW'(0);
   localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(SONG_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2,
      S_PLAY  = 2'd3
   } state_t;

   state_t           r_state;
   logic [AW-1:0]    r_addr;
   logic [DIV_W-1:0] r_hp;
   logic [DUR_W-1:0] r_dur;
   logic [TW-1:0]    r_tick_cnt;
   logic [DUR_W-1:0] r_tick_num;
   logic [DIV_W-1:0] r_tone_cnt;
   logic             r_phase;
   logic             r_speaker;
   logic             r_busy;
   logic             r_done;

   logic             w_tick_wrap;
   logic [DUR_W-1:0] w_tick_num_nxt;
   logic             w_note_end;
   logic             w_tone_wrap;
   logic             w_phase_nxt;
   logic             w_last_addr;
   logic             w_gap;
   logic [DIV_W-1:0] w_data_hp;
   logic [DUR_W-1:0] w_data_dur;

   always_comb begin
      w_data_hp      = song_data[DIV_W+DUR_W-1:DUR_W];
      w_data_dur     = song_data[DUR_W-1:0];
      w_tick_wrap    = (r_tick_cnt == TICK_LAST);
      w_tick_num_nxt = w_tick_wrap ? (r_tick_num + DUR_ONE) : r_tick_num;
      w_note_end     = w_tick_wrap && (w_tick_num_nxt == r_dur);
      w_tone_wrap    = (r_hp != HP_ZERO) && (r_tone_cnt == (r_hp - HP_ONE));
      w_phase_nxt    = w_tone_wrap ? ~r_phase : r_phase;
      w_last_addr    = (r_addr == LAST_ADDR);
`ifdef TONE_SEQ_ARTIC_GAP_EN
      // Looks one cycle ahead because speaker is registered.
      w_gap          = (r_dur >= DUR_W'(2)) && (w_tick_num_nxt == (r_dur - DUR_ONE));
`else
      w_gap          = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= ADDR_ZERO;
         r_hp       <= HP_ZERO;
         r_dur      <= DUR_ZERO;
         r_tick_cnt <= TICK_ZERO;
         r_tick_num <= DUR_ZERO;
         r_tone_cnt <= HP_ZERO;
         r_phase    <= 1'b0;
         r_speaker  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            r_state   <= S_IDLE;
            r_speaker <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_speaker <= 1'b0;
                  if (start) begin
                     r_addr  <= ADDR_ZERO;
                     r_state <= S_FETCH;
                     r_busy  <= 1'b1;
                  end else begin
                     r_busy  <= 1'b0;
                  end
               end
               S_FETCH: begin
                  r_speaker <= 1'b0;
                  r_state   <= S_LOAD;
               end
               S_LOAD: begin
                  r_speaker <= 1'b0;
                  r_hp      <= w_data_hp;
                  r_dur     <= w_data_dur;
                  if (w_data_dur == DUR_ZERO) begin
                     // Looping from address 0 would replay an empty song forever.
                     if (loop && (r_addr != ADDR_ZERO)) begin
                        r_addr  <= ADDR_ZERO;
                        r_state <= S_FETCH;
                     end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_tick_cnt <= TICK_ZERO;
                     r_tick_num <= DUR_ZERO;
                     r_tone_cnt <= HP_ZERO;
                     r_phase    <= 1'b0;
                     r_state    <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  r_tick_cnt <= w_tick_wrap ? TICK_ZERO : (r_tick_cnt + TICK_ONE);
                  r_tick_num <= w_tick_num_nxt;
                  if (r_hp == HP_ZERO) begin
                     r_tone_cnt <= HP_ZERO;
                  end else begin
                     r_tone_cnt <= w_tone_wrap ? HP_ZERO : (r_tone_cnt + HP_ONE);
                  end
                  r_phase <= w_phase_nxt;
                  if (w_note_end) begin
                     r_speaker <= 1'b0;
                     if (w_last_addr) begin
                        if (loop) begin
                           r_addr  <= ADDR_ZERO;
                           r_state <= S_FETCH;
                        end else begin
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
                           r_state <= S_IDLE;
                        end
                     end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_state <= S_FETCH;
                     end
                  end else begin
                     r_speaker <= w_gap ? 1'b0 : w_phase_nxt;
                  end
               end
               default: begin
                  r_state   <= S_IDLE;
                  r_speaker <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign song_addr = r_addr;
   assign speaker   = r_speaker;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomised scoreboard bench for tone_sequencer: a per-cycle reference trace is queued at start and a negedge monitor compares it.
`timescale 1ns/1ps
module tb_tone_sequencer;

   localparam int CLK_HZ   = 1000;
   localparam int TICK_HZ  = 10;
   localparam int SONG_LEN = 4;
   localparam int DIV_W    = 6;
   localparam int DUR_W    = 3;
   localparam int AW       = 2;
   localparam int T        = CLK_HZ / TICK_HZ;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic loop_lvl = 1'b0;
   logic [AW-1:0] song_addr;
   logic [DIV_W+DUR_W-1:0] song_data = '0;
   logic speaker, busy, done;

   logic [DIV_W-1:0] mem_hp  [SONG_LEN];
   logic [DUR_W-1:0] mem_dur [SONG_LEN];

   typedef struct packed {
      logic          spk;
      logic          bsy;
      logic          dn;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   tone_sequencer #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SONG_LEN(SONG_LEN),
      .DIV_W(DIV_W), .DUR_W(DUR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop_lvl),
      .song_addr(song_addr), .song_data(song_data),
      .speaker(speaker), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) song_data <= {mem_hp[song_addr], mem_dur[song_addr]};

   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {speaker, busy, done, song_addr};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL trace t=%0t spk/busy/done/addr got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     $time, a.spk, a.bsy, a.dn, a.addr, e.spk, e.bsy, e.dn, e.addr);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   function automatic void add(input logic s, input logic b, input logic d, input int a);
      exp_q.push_back({s, b, d, AW'(a)});
   endfunction

   // Expected per-cycle trace, cycle 0 being the first cycle after start is accepted.
   task automatic build_model(input int stop_at, input int max_len);
      int   a = 0;
      bit   fin = 0;
      int   d, h;
      logic s;
      exp_t last;
      while (!fin && exp_q.size() < max_len) begin
         add(1'b0, 1'b1, 1'b0, a);
         add(1'b0, 1'b1, 1'b0, a);
         d = int'(mem_dur[a]);
         h = int'(mem_hp[a]);
         if (d == 0) begin
            if (loop_lvl && a != 0) a = 0;
            else begin add(1'b0, 1'b0, 1'b1, a); fin = 1; end
         end else begin
            for (int k = 0; k < d * T; k++) begin
               s = (h == 0) ? 1'b0 : (((k / h) % 2) == 1);
`ifdef TONE_SEQ_ARTIC_GAP_EN
               if (d >= 2 && k >= (d - 1) * T) s = 1'b0;
`endif
               add(s, 1'b1, 1'b0, a);
            end
            if (a == SONG_LEN - 1) begin
               if (loop_lvl) a = 0;
               else begin add(1'b0, 1'b0, 1'b1, a); fin = 1; end
            end else begin
               a++;
            end
         end
      end
      if (stop_at >= 0 && stop_at < exp_q.size()) begin
         last = exp_q[stop_at];
         while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
         repeat (3) add(1'b0, 1'b0, 1'b0, int'(last.addr));
      end else if (fin) begin
         last = exp_q[$];
         repeat (3) add(1'b0, 1'b0, 1'b0, int'(last.addr));
      end
   endtask

   task automatic start_song(input int stop_at);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      build_model(stop_at, 4000);
   endtask

   // Drives stop (optionally with start) and an ignored start pulse, then waits for the trace to drain.
   task automatic run_song(input int stop_at, input bit collide, input int ign_at);
      int c = 0;
      start_song(stop_at);
      while (exp_q.size() > 0 && c < 5000) begin
         stop  = (c == stop_at);
         start = (c == ign_at) || (collide && c == stop_at);
         @(posedge clk); #1;
         stop  = 1'b0;
         start = 1'b0;
         c++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout left %0d want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic set_entry(input int i, input int hp, input int dur);
      mem_hp[i]  = DIV_W'(hp);
      mem_dur[i] = DUR_W'(dur);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < SONG_LEN; i++) set_entry(i, 0, 0);
      #23;
      chk("rst_speaker", {31'd0, speaker}, 32'd0);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_addr",    {30'd0, song_addr}, 32'd0);
      rst_n = 1'b1;

      // Single note then end marker.
      set_entry(0, 5, 2); set_entry(1, 7, 0);
      loop_lvl = 1'b0;
      run_song(-1, 1'b0, -1);

      // Rest, tone, end marker with looping, stopped after several passes.
      set_entry(0, 0, 1); set_entry(1, 3, 1); set_entry(2, 0, 0);
      loop_lvl = 1'b1;
      run_song(650, 1'b0, -1);

      // start and stop together during PLAY, then a clean restart.
      set_entry(0, 4, 3); set_entry(1, 0, 0);
      loop_lvl = 1'b0;
      run_song(150, 1'b1, -1);
      run_song(-1, 1'b0, 1);

      // Every entry plays, finishing at the last address without wrapping.
      for (int i = 0; i < SONG_LEN; i++) set_entry(i, i + 1, 1);
      run_song(-1, 1'b0, -1);

      // Async reset while the speaker is high.
      set_entry(0, 5, 2); set_entry(1, 0, 0);
      start_song(-1);
      guard = 0;
      while (speaker !== 1'b1 && guard < 500) begin @(posedge clk); #1; guard++; end
      chk("spk_high_before_rst", {31'd0, speaker}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_speaker", {31'd0, speaker}, 32'd0);
      chk("midrst_busy",    {31'd0, busy},    32'd0);
      chk("midrst_addr",    {30'd0, song_addr}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;

      // Randomised songs.
      for (int r = 0; r < 10; r++) begin
         int sa;
         for (int i = 0; i < SONG_LEN; i++)
            set_entry(i, int'($urandom % 8), ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 3)));
         loop_lvl = $urandom % 2;
         if (loop_lvl) sa = int'($urandom_range(5, 1500));
         else sa = ($urandom % 2 == 1) ? int'($urandom_range(0, 800)) : -1;
         run_song(sa, 1'(($urandom % 2)), loop_lvl ? -1 : 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed single-song music generator that drives the speaker pin.
- Plays a song stored in an external synchronous-read memory. Each entry holds a tone half-period and a duration in tempo ticks.
- Produces a square wave on `speaker`, with start/stop control, optional looping and a done pulse.
- Sits between the song memory and the top-level `speaker` output.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TICK_HZ, 16, tempo ticks per second. Tick period = CLK_HZ/TICK_HZ cycles (integer division; must be at least 2).
- SONG_LEN, 64, number of song entries; AW = $clog2(SONG_LEN).
- DIV_W, 20, width of the half-period field, in clk cycles.
- DUR_W, 4, width of the duration field, in ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin playback at entry 0
- stop  in  1  single-cycle pulse; abort playback
- loop  in  1  level; sampled at the end marker
- song_addr  out  AW  song memory address
- song_data  in  DIV_W+DUR_W  {half_period, dur}; valid one cycle after song_addr
- speaker  out  1  square-wave output, registered
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when playback ends naturally

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; speaker=0, busy=0, done=0, song_addr=0.
  - All counters cleared.
  - Reset asserted mid-note silences `speaker` immediately.
- States: IDLE, FETCH, LOAD, PLAY.
- IDLE:
  - start=1 -> song_addr=0, go to FETCH.
- FETCH:
  - One wait cycle for the memory read latency. Then go to LOAD.
- LOAD:
  - Capture song_data into hp (half_period) and dur.
  - dur==0 is the end marker:
    - If loop=1 and song_addr!=0: song_addr=0, go to FETCH.
    - Otherwise: done=1 for one cycle, go to IDLE. An end marker at address 0 therefore never loops forever.
  - dur!=0: clear the tick counter, tick count, tone counter and tone phase; go to PLAY.
- PLAY:
  - Tick counter runs 0..CLK_HZ/TICK_HZ-1 and wraps; each wrap increments the tick count.
  - When the tick count reaches dur:
    - If song_addr==SONG_LEN-1: behave as an end marker (loop -> address 0; else done and IDLE).
    - Else song_addr+1, go to FETCH.
  - Note length is exactly dur*(CLK_HZ/TICK_HZ) cycles in PLAY. Each note boundary adds 2 cycles (FETCH+LOAD).
- Tone:
  - In PLAY with hp!=0, the tone counter runs 0..hp-1; on wrap the phase toggles.
  - speaker = phase, registered. The first rising edge appears hp cycles after PLAY entry; output frequency is CLK_HZ/(2*hp).
  - hp==0 is a rest: speaker=0 for the whole note.
  - In FETCH, LOAD and IDLE, speaker=0.
- Control:
  - start while busy is ignored.
  - stop in any non-IDLE state -> IDLE on the next edge; speaker=0 and busy=0 in that same edge; no done pulse.
  - start and stop in the same cycle: stop wins, and the block stays in or returns to IDLE.
  - loop is sampled only at an end marker or at the SONG_LEN-1 boundary.
- song_addr holds its value throughout a note. Its width wraps naturally only through the explicit reset to 0.

Optional Feature:
- Macro: TONE_SEQ_ARTIC_GAP_EN.
- When defined: during the final tick of every note with dur>=2, speaker is forced to 0 and the tone counter keeps running. This makes repeated equal notes audibly separated. Notes with dur==1 are unaffected.
- When undefined: no gap; speaker follows the tone phase for the whole note.

Test Plan (CLK_HZ=1000, TICK_HZ=10 -> 100 cycles/tick):
- Reset mid-note: assert rst_n=0 while speaker=1 -> speaker=0, busy=0, song_addr=0 asynchronously, before the next clk edge.
- Single note: entry0={hp=5,dur=2}, entry1={x,dur=0}, pulse start -> speaker toggles every 5 cycles for 200 cycles; then song_addr=1; done pulses once; busy falls.
- Rest and loop: entry0={hp=0,dur=1}, entry1={hp=3,dur=1}, entry2 end marker, loop=1 -> 100 silent cycles, then 100 cycles of period-6 tone; song_addr returns to 0 and the sequence repeats; done never pulses.
- Stop/start collision: during PLAY, assert start and stop together -> IDLE next cycle, speaker=0, no done; a later start alone restarts at address 0.
- Address wrap: SONG_LEN=4, all entries dur=1, loop=0 -> after entry 3 finishes, done pulses and no fetch of address 4/0 occurs.
- Gap feature (macro defined): entry {hp=2,dur=3} -> tone for 200 cycles, speaker=0 for the final 100 cycles.
